ov5640_init_sequencer: RTL and testbench

//  Walks the OV5640 init register ROM (synchronous, 1-cycle read latency, 24-bit {reg_addr[15:0],reg_data[7:0]}

---
 rtl/ov5640_init_sequencer.sv | 105 ++++++++++
 tb/tb_ov5640_init_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ov5640_init_sequencer.sv
// ov5640_init_sequencer: streams the init ROM to the SCCB write master, with post-reset settle delay and NACK retry
module ov5640_init_sequencer #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 24,
  parameter int REG_NUM      = 250,
  parameter int RESET_IDX    = 1,
  parameter int DELAY_CYCLES = 250000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic                  wr_req,
  output logic [15:0]           wr_addr,
  output logic [7:0]            wr_data,
  input  logic                  wr_done,
  input  logic                  wr_nack,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_err
);
  localparam int CW = DELAY_CYCLES > 0 ? $clog2(DELAY_CYCLES + 1) : 1;
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(REG_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] RST_I = ADDR_WIDTH'(RESET_IDX);
  localparam logic [CW-1:0] CNT_END = CW'(DELAY_CYCLES > 0 ? DELAY_CYCLES - 1 : 0);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, REQ, DELAY, DONE, ERR} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [RW-1:0] retry;
  logic [CW-1:0] cnt;
  logic hold;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rom_addr <= '0;
      wr_req <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy <= 1'b0;
      init_done <= 1'b0;
      init_err <= 1'b0;
      idx <= '0;
      retry <= '0;
      cnt <= '0;
      hold <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state <= FETCH;
          idx <= '0;
          busy <= 1'b1;
          init_done <= 1'b0;
          init_err <= 1'b0;
        end
        FETCH: begin
          rom_addr <= idx;
          hold <= 1'b0;
          state <= LATCH;
        end
        // rom_addr leaves FETCH registered, so the ROM word is only valid on the second LATCH cycle
        LATCH: begin
          hold <= 1'b1;
          if (hold) begin
            wr_addr <= rom_q[23:8];
            wr_data <= rom_q[7:0];
            retry <= '0;
            wr_req <= 1'b1;
            state <= REQ;
          end
        end
        REQ: if (!wr_req) wr_req <= 1'b1;
        else if (wr_done) begin
          wr_req <= 1'b0;
          if (!wr_nack) begin
            if (idx == LAST) begin
              state <= DONE;
              busy <= 1'b0;
              init_done <= 1'b1;
            end else if (idx == RST_I && DELAY_CYCLES != 0) begin
              cnt <= '0;
              state <= DELAY;
            end else begin
              idx <= idx + 1'b1;
              state <= FETCH;
            end
          end else if (retry < RMAX) retry <= retry + 1'b1;
          else begin
            state <= ERR;
            busy <= 1'b0;
            init_err <= 1'b1;
          end
        end
        DELAY: if (cnt == CNT_END) begin
          idx <= idx + 1'b1;
          state <= FETCH;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// tb_ov5640_init_sequencer: directed checks of ordering, timing, settle delay, retry, abort and reset
module tb_ov5640_init_sequencer;
  localparam int DLY = 100;
  logic clk = 0, reset = 1, start = 0, wr_done = 0, wr_nack = 0;
  logic [7:0] rom_addr;
  logic [23:0] rom_q = '0;
  logic wr_req, busy, init_done, init_err;
  logic [15:0] wr_addr;
  logic [7:0] wr_data;
  int checks = 0, errors = 0, cyc = 0, t_start = 0, t_done = 0;
  logic [15:0] got_a;
  logic [7:0] got_d;
  logic [23:0] rom [4] = '{24'h310311, 24'h300882, 24'h300842, 24'h310303};
  logic [15:0] exp_a [4] = '{16'h3103, 16'h3008, 16'h3008, 16'h3103};
  logic [7:0] exp_d [4] = '{8'h11, 8'h82, 8'h42, 8'h03};
  ov5640_init_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(24), .REG_NUM(4), .RESET_IDX(1),
    .DELAY_CYCLES(DLY), .MAX_RETRY(3)) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_q(rom_q),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .wr_nack(wr_nack), .busy(busy), .init_done(init_done), .init_err(init_err));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rom_q <= rom[rom_addr[1:0]];
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic rst_check();
    check("rst_flags", {28'd0, busy, init_done, init_err, wr_req}, 0);
    check("rst_wr", {8'd0, wr_addr, wr_data}, 0);
    check("rst_rom", {24'd0, rom_addr}, 0);
  endtask
  task automatic do_start();
    start = 1;
    t_start = cyc + 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic serve(input bit nack, output int t_req);
    int n;
    bit stable;
    n = 0;
    t_req = -1;
    while (!wr_req && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!wr_req) begin
      check("req_timeout", 0, 1);
      return;
    end
    t_req = cyc;
    got_a = wr_addr;
    got_d = wr_data;
    stable = 1;
    repeat (5) begin
      @(negedge clk);
      if (!wr_req || wr_addr !== got_a || wr_data !== got_d) stable = 0;
    end
    check("req_stable", {31'd0, stable}, 1);
    wr_done = 1;
    wr_nack = nack;
    t_done = cyc + 1;
    @(negedge clk);
    wr_done = 0;
    wr_nack = 0;
    check("req_drop", {31'd0, wr_req}, 0);
  endtask
  task automatic seq(input int nk_idx, input int nk_n, input bit spur);
    int tries, pd, t, gap;
    bit quiet;
    do_start();
    check("busy_start", {29'd0, busy, init_done, init_err}, 3'b100);
    for (int i = 0; i < 4; i++) begin
      tries = (i == nk_idx) ? ((nk_n > 3) ? 4 : nk_n + 1) : 1;
      for (int j = 0; j < tries; j++) begin
        pd = t_done;
        serve(i == nk_idx && j < nk_n, t);
        check("wr_addr", {16'd0, got_a}, {16'd0, exp_a[i]});
        check("wr_data", {24'd0, got_d}, {24'd0, exp_d[i]});
        gap = (i == 0 && j == 0) ? t - t_start : t - pd;
        check("req_timing", gap, (i == 0 && j == 0) ? 3 : (j > 0) ? 1 : (i == 2) ? DLY + 3 : 3);
        if (spur && i == 0) begin
          wr_done = 1;
          start = 1;
          @(negedge clk);
          wr_done = 0;
          start = 0;
        end
      end
      if (i == nk_idx && nk_n > 3) begin
        check("err_flags", {29'd0, busy, init_done, init_err}, 3'b001);
        check("err_rom_addr", {24'd0, rom_addr}, 2);
        quiet = 1;
        repeat (10) begin
          @(negedge clk);
          if (wr_req) quiet = 0;
        end
        check("err_quiet", {31'd0, quiet}, 1);
        return;
      end
    end
    check("done_flags", {29'd0, busy, init_done, init_err}, 3'b010);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_check();
    reset = 0;
    @(negedge clk);
    seq(-1, 0, 0);
    seq(2, 2, 0);
    seq(2, 4, 0);
    seq(-1, 0, 0);
    seq(-1, 0, 1);
    do_start();
    n = 0;
    while (!wr_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_req", {31'd0, wr_req}, 1);
    reset = 1;
    @(negedge clk);
    rst_check();
    reset = 0;
    @(negedge clk);
    seq(-1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
